// File: rtl/axi3_regbus_s.sv
// AXI3 slave bridge from a PS7 GP port onto a word-wide register bus.
// Independent write (AW/W/B) and read (AR/R) FSMs; one register access per beat.
module axi3_regbus_s #(
    parameter int NREGS  = 16,
    parameter int REG_AW = 4
) (
    input  logic              i_clk0,
    input  logic              i_rst,
    input  logic [11:0]       i_AWID,
    input  logic [31:0]       i_AWADDR,
    input  logic [3:0]        i_AWLEN,
    input  logic [1:0]        i_AWBURST,
    input  logic              i_AWVALID,
    output logic              o_AWREADY,
    input  logic [31:0]       i_WDATA,
    input  logic [3:0]        i_WSTRB,
    input  logic              i_WLAST,
    input  logic              i_WVALID,
    output logic              o_WREADY,
    output logic [11:0]       o_BID,
    output logic [1:0]        o_BRESP,
    output logic              o_BVALID,
    input  logic              i_BREADY,
    input  logic [11:0]       i_ARID,
    input  logic [31:0]       i_ARADDR,
    input  logic [3:0]        i_ARLEN,
    input  logic [1:0]        i_ARBURST,
    input  logic              i_ARVALID,
    output logic              o_ARREADY,
    output logic [11:0]       o_RID,
    output logic [31:0]       o_RDATA,
    output logic [1:0]        o_RRESP,
    output logic              o_RLAST,
    output logic              o_RVALID,
    input  logic              i_RREADY,
    output logic              o_reg_wr_en,
    output logic [REG_AW-1:0] o_reg_wr_addr,
    output logic [31:0]       o_reg_wr_data,
    output logic [3:0]        o_reg_wr_strb,
    output logic              o_reg_rd_en,
    output logic [REG_AW-1:0] o_reg_rd_addr,
    input  logic [31:0]       i_reg_rd_data
);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [10:0] IDX_LIMIT   = 11'(NREGS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_CAP, R_DATA} r_state_t;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_AWADDR[31:12], i_AWADDR[1:0], i_ARADDR[31:12], i_ARADDR[1:0]};

    // Keeps both address READYs low until the first clock edge after reset release.
    logic live;
    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_state_nxt;
    logic [11:0] w_id;
    logic [10:0] w_idx;
    logic [3:0]  w_len, w_cnt;
    logic [1:0]  w_burst, w_resp, w_beat_resp;
    logic        aw_hs, w_hs, b_hs, w_last_beat, w_oob, w_supp;

    assign o_AWREADY   = live && (w_state == W_IDLE);
    assign o_WREADY    = (w_state == W_DATA);
    assign o_BVALID    = (w_state == W_RESP);
    assign o_BID       = w_id;
    assign o_BRESP     = w_resp;
    assign aw_hs       = o_AWREADY && i_AWVALID;
    assign w_hs        = o_WREADY && i_WVALID;
    assign b_hs        = o_BVALID && i_BREADY;
    assign w_last_beat = (w_cnt == w_len);
    // 11-bit index so a burst running past 0x3FF stays out of the map.
    assign w_oob       = (w_idx >= IDX_LIMIT);
    assign w_supp      = w_oob || w_burst[1];

    always_comb begin
        w_beat_resp = RESP_OKAY;
        if (w_oob)
            w_beat_resp = RESP_DECERR;
        else if (w_burst[1] || (i_WLAST != w_last_beat))
            w_beat_resp = RESP_SLVERR;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= '0;
            w_resp        <= RESP_OKAY;
            o_reg_wr_en   <= 1'b0;
            o_reg_wr_addr <= '0;
            o_reg_wr_data <= '0;
            o_reg_wr_strb <= '0;
        end else begin
            o_reg_wr_en <= 1'b0;
            if (aw_hs) begin
                w_id    <= i_AWID;
                w_idx   <= {1'b0, i_AWADDR[11:2]};
                w_len   <= i_AWLEN;
                w_burst <= i_AWBURST;
                w_cnt   <= '0;
                w_resp  <= RESP_OKAY;
            end
            if (w_hs) begin
                o_reg_wr_en   <= !w_supp;
                o_reg_wr_addr <= w_idx[REG_AW-1:0];
                o_reg_wr_data <= i_WDATA;
                o_reg_wr_strb <= i_WSTRB;
                w_cnt         <= w_cnt + 4'd1;
                if (w_burst == BURST_INCR) w_idx <= w_idx + 11'd1;
                if (w_beat_resp > w_resp)  w_resp <= w_beat_resp;
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state, r_state_nxt;
    logic [11:0] r_id;
    logic [10:0] r_idx, r_idx_nxt;
    logic [3:0]  r_len, r_cnt;
    logic [1:0]  r_burst, r_burst_nxt, r_beat_resp;
    logic        ar_hs, r_hs, r_last, r_supp, rd_en_nxt;

    assign o_ARREADY = live && (r_state == R_IDLE);
    assign o_RVALID  = (r_state == R_DATA);
    assign o_RID     = r_id;
    assign r_last    = (r_cnt == r_len);
    assign o_RLAST   = o_RVALID && r_last;
    assign ar_hs     = o_ARREADY && i_ARVALID;
    assign r_hs      = o_RVALID && i_RREADY;
    assign r_supp    = (r_idx >= IDX_LIMIT) || r_burst[1];

    always_comb begin
        r_beat_resp = RESP_OKAY;
        if (r_idx >= IDX_LIMIT) r_beat_resp = RESP_DECERR;
        else if (r_burst[1])    r_beat_resp = RESP_SLVERR;
    end

    // Next index/burst are resolved here so the read strobe can be registered
    // on the same edge that enters R_REQ.
    always_comb begin
        r_state_nxt = r_state;
        r_idx_nxt   = r_idx;
        r_burst_nxt = r_burst;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                r_state_nxt = R_REQ;
                r_idx_nxt   = {1'b0, i_ARADDR[11:2]};
                r_burst_nxt = i_ARBURST;
            end
            R_REQ:  r_state_nxt = R_CAP;
            R_CAP:  r_state_nxt = R_DATA;
            R_DATA: if (r_hs) begin
                if (r_last) begin
                    r_state_nxt = R_IDLE;
                end else begin
                    r_state_nxt = R_REQ;
                    if (r_burst == BURST_INCR) r_idx_nxt = r_idx + 11'd1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
        rd_en_nxt = (r_state_nxt == R_REQ) && (r_idx_nxt < IDX_LIMIT) && !r_burst_nxt[1];
    end

    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            r_id          <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= '0;
            o_RDATA       <= '0;
            o_RRESP       <= RESP_OKAY;
            o_reg_rd_en   <= 1'b0;
            o_reg_rd_addr <= '0;
        end else begin
            r_idx       <= r_idx_nxt;
            r_burst     <= r_burst_nxt;
            o_reg_rd_en <= rd_en_nxt;
            if (rd_en_nxt) o_reg_rd_addr <= r_idx_nxt[REG_AW-1:0];
            if (ar_hs) begin
                r_id  <= i_ARID;
                r_len <= i_ARLEN;
                r_cnt <= '0;
            end
            if (r_hs && !r_last) r_cnt <= r_cnt + 4'd1;
            if (r_state == R_CAP) begin
                o_RDATA <= r_supp ? '0 : i_reg_rd_data;
                o_RRESP <= r_beat_resp;
            end
        end
    end
endmodule
